cgra_config_receiver: RTL and testbench

- Receive end of the serial CGRA configuration protocol.
- Sits beside the bitstream configurator.
- Samples the 1-bit registered bitstream, assembles it into a TOTAL_NUM_BITS parallel configuration vector, and checks the transfer against the transmitter's done flag.
- Presents the vector to the fabric with a validity flag, plus error status for bring-up and verification.

---
 rtl/cgra_config_receiver.sv | 149 ++++++++++++++
 tb/tb_cgra_config_receiver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_config_receiver.sv
// rtl/cgra_config_receiver.sv - receive end of the serial CGRA configuration protocol
//
// Purpose:
//   Mirrors the transmitter's one-cycle output register to know when the
//   1-bit bitstream carries a live bit, shifts those bits into a parallel
//   configuration vector (first bit received ends up in the MSB), and checks
//   the frame against the transmitter's done flag.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   sync_reset   synchronous restart, shared with the transmitter
//   enable       transmitter enable (same net)
//   bitstream    registered serial data from the transmitter
//   done         transmitter done flag
//   config_out   assembled configuration vector
//   config_valid frame complete and confirmed by done
//   busy         frame in progress (LOADING or LOADED)
//   bit_count    number of bits captured so far
//   error        sticky protocol error
//   error_code   01 = underflow (done before frame complete), 10 = done dropped

module cgra_config_receiver #(
  parameter int TOTAL_NUM_BITS = 465,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sync_reset,
  input  logic                      enable,
  input  logic                      bitstream,
  input  logic                      done,
  output logic [TOTAL_NUM_BITS-1:0] config_out,
  output logic                      config_valid,
  output logic                      busy,
  output logic [COUNT_WIDTH-1:0]    bit_count,
  output logic                      error,
  output logic [1:0]                error_code
);

  localparam logic [COUNT_WIDTH-1:0] TOTAL = COUNT_WIDTH'(TOTAL_NUM_BITS);

  localparam logic [1:0] CODE_NONE      = 2'b00;
  localparam logic [1:0] CODE_UNDERFLOW = 2'b01;
  localparam logic [1:0] CODE_DROPPED   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOADING,
    LOADED,
    DONE,
    ERROR
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [1:0]               code_d;
  logic [COUNT_WIDTH-1:0]   issue_count;
  logic                     pending;
  logic                     issue;
  logic [COUNT_WIDTH-1:0]   count_next;

  // The transmitter emits a bit on every enabled edge until it has sent the
  // whole frame; that bit appears on bitstream one edge later, which is when
  // pending says it is safe to sample.
  assign issue = enable && !sync_reset && (issue_count < TOTAL);

  // Count as it will be after this edge's capture; state decisions use it so
  // that a done arriving together with the final bit does not look like an
  // underflow.
  assign count_next = bit_count + COUNT_WIDTH'(pending);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_count <= '0;
      pending     <= 1'b0;
      config_out  <= '0;
      bit_count   <= '0;
      state_q     <= IDLE;
      error_code  <= CODE_NONE;
    end else if (sync_reset) begin
      issue_count <= '0;
      pending     <= 1'b0;
      config_out  <= '0;
      bit_count   <= '0;
      state_q     <= IDLE;
      error_code  <= CODE_NONE;
    end else begin
      pending <= issue;
      if (issue) begin
        issue_count <= issue_count + 1'b1;
      end
      if (pending) begin
        config_out <= {config_out[TOTAL_NUM_BITS-2:0], bitstream};
        bit_count  <= count_next;
      end
      state_q    <= state_d;
      error_code <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = error_code;
    case (state_q)
      IDLE: begin
        if (pending && (count_next == TOTAL)) begin
          state_d = LOADED;
        end else if (done) begin
          state_d = ERROR;
          code_d  = CODE_UNDERFLOW;
        end else if (pending) begin
          state_d = LOADING;
        end
      end
      LOADING: begin
        if (count_next == TOTAL) begin
          state_d = LOADED;
        end else if (done) begin
          state_d = ERROR;
          code_d  = CODE_UNDERFLOW;
        end
      end
      LOADED: begin
        if (done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!done) begin
          state_d = ERROR;
          code_d  = CODE_DROPPED;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
        code_d  = CODE_NONE;
      end
    endcase
  end

  assign busy         = (state_q == LOADING) || (state_q == LOADED);
  assign config_valid = (state_q == DONE);
  assign error        = (state_q == ERROR);

endmodule

// File: tb/tb_cgra_config_receiver.sv
// tb/tb_cgra_config_receiver.sv - randomized self-checking bench for cgra_config_receiver

module tb_cgra_config_receiver;

  localparam int N  = 8;
  localparam int NB = 465;

  logic          clock;
  logic          reset;
  logic          sync_reset;
  logic          enable;
  logic          bitstream;
  logic          done;
  logic [N-1:0]  config_out;
  logic          config_valid;
  logic          busy;
  logic [31:0]   bit_count;
  logic          error;
  logic [1:0]    error_code;

  logic          big_sync_reset;
  logic          big_enable;
  logic          big_bitstream;
  logic          big_done;
  logic [NB-1:0] big_config_out;
  logic          big_config_valid;
  logic          big_busy;
  logic [31:0]   big_bit_count;
  logic          big_error;
  logic [1:0]    big_error_code;

  cgra_config_receiver #(.TOTAL_NUM_BITS(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .sync_reset   (sync_reset),
    .enable       (enable),
    .bitstream    (bitstream),
    .done         (done),
    .config_out   (config_out),
    .config_valid (config_valid),
    .busy         (busy),
    .bit_count    (bit_count),
    .error        (error),
    .error_code   (error_code)
  );

  cgra_config_receiver dut_big (
    .clock        (clock),
    .reset        (reset),
    .sync_reset   (big_sync_reset),
    .enable       (big_enable),
    .bitstream    (big_bitstream),
    .done         (big_done),
    .config_out   (big_config_out),
    .config_valid (big_config_valid),
    .busy         (big_busy),
    .bit_count    (big_bit_count),
    .error        (big_error),
    .error_code   (big_error_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model and reference state. done_force: 0 normal, 1 force
  // high, 2 force low, 3 raise done together with the final bit.
  logic [N-1:0] frame;
  int           tx_idx;
  int           done_force;
  bit           prev_issued;
  int           exp_captured;
  bit           exp_valid;
  bit           exp_error;
  logic [1:0]   exp_code;

  task automatic model_clear();
    tx_idx       = 0;
    prev_issued  = 0;
    exp_captured = 0;
    exp_valid    = 0;
    exp_error    = 0;
    exp_code     = 2'b00;
  endtask

  task automatic step(input logic en, input logic sr);
    logic       d_sampled;
    int         cap_before;
    bit         issued;
    logic [N-1:0] exp_cfg;
    enable     = en;
    sync_reset = sr;
    d_sampled  = done;
    @(posedge clock);
    #1;
    issued = 0;
    if (sr) begin
      model_clear();
      bitstream = 1'($urandom);
      done      = 1'b0;
    end else begin
      cap_before = exp_captured;
      if (prev_issued) exp_captured++;
      if (!exp_error) begin
        if (exp_valid) begin
          if (!d_sampled) begin
            exp_valid = 0; exp_error = 1; exp_code = 2'b10;
          end
        end else if (d_sampled) begin
          if (exp_captured == N && cap_before == N) exp_valid = 1;
          else if (exp_captured < N) begin
            exp_error = 1; exp_code = 2'b01;
          end
        end
      end
      done = (tx_idx == N);
      if (en && tx_idx < N) begin
        bitstream = frame[N-1-tx_idx];
        tx_idx++;
        issued = 1;
      end else begin
        bitstream = 1'($urandom);
      end
      prev_issued = issued;
      if (done_force == 1) done = 1'b1;
      else if (done_force == 2) done = 1'b0;
      else if (done_force == 3) done = (tx_idx == N);
    end
    exp_cfg = (exp_captured == 0) ? '0 : N'(frame >> (N - exp_captured));
    check_eq("bit_count", bit_count, 32'(exp_captured));
    check_eq("config_valid", config_valid, exp_valid);
    check_eq("error", error, exp_error);
    check_eq("error_code", error_code, exp_code);
    check_eq("busy", busy, !exp_error && !exp_valid && exp_captured > 0);
    if (!exp_error) check_eq("config_out", config_out, exp_cfg);
  endtask

  logic [NB-1:0] big_frame;
  logic [NB-1:0] big_care;
  int            big_idx;

  initial begin
    reset = 1'b1; sync_reset = 1'b0; enable = 1'b0; bitstream = 1'b0; done = 1'b0;
    big_sync_reset = 1'b0; big_enable = 1'b0; big_bitstream = 1'b0; big_done = 1'b0;
    frame = 8'hB2; done_force = 0;
    model_clear();
    #2;
    check_eq("rst_config_out", config_out, 8'h00);
    check_eq("rst_valid", config_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_bit_count", bit_count, 32'd0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_error_code", error_code, 2'b00);
    @(negedge clock);
    reset = 1'b0;

    // Pattern B2, enable held high.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    check_eq("b2_after_9_edges", config_out, 8'hB2);
    step(1'b1, 1'b0);
    check_eq("b2_valid", config_valid, 1'b1);
    check_eq("b2_busy", busy, 1'b0);
    check_eq("b2_error", error, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // Same pattern with enable toggling every cycle.
    step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'((i + 1) % 2), 1'b0);
    check_eq("toggle_cfg", config_out, 8'hB2);
    check_eq("toggle_count", bit_count, 32'd8);
    check_eq("toggle_error", error, 1'b0);

    // sync_reset after 5 bits, then 5A re-sent.
    step(1'b0, 1'b1);
    frame = 8'($urandom);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    check_eq("pre_sr_count", bit_count, 32'd5);
    step(1'b1, 1'b1);
    check_eq("sr_count", bit_count, 32'd0);
    check_eq("sr_busy", busy, 1'b0);
    frame = 8'h5A;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    check_eq("5a_cfg", config_out, 8'h5A);
    check_eq("5a_valid", config_valid, 1'b1);

    // Underflow: done forced high after 3 captures.
    step(1'b0, 1'b1);
    frame = 8'($urandom);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    done_force = 1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    check_eq("uf_error", error, 1'b1);
    check_eq("uf_code", error_code, 2'b01);
    check_eq("uf_valid", config_valid, 1'b0);
    done_force = 0;
    step(1'b0, 1'b1);
    check_eq("uf_cleared", error, 1'b0);

    // Done dropped after a valid frame.
    frame = 8'($urandom);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
    check_eq("drop_pre_valid", config_valid, 1'b1);
    done_force = 2;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check_eq("drop_error", error, 1'b1);
    check_eq("drop_code", error_code, 2'b10);
    check_eq("drop_valid", config_valid, 1'b0);
    done_force = 0;

    // done arriving on the same edge as the final capture.
    step(1'b0, 1'b1);
    frame = 8'($urandom);
    done_force = 3;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    check_eq("early_done_valid", config_valid, 1'b1);
    check_eq("early_done_error", error, 1'b0);
    done_force = 0;

    // Randomized frames with random enable density and rare restarts.
    for (int f = 0; f < 15; f++) begin
      int density;
      step(1'b0, 1'b1);
      frame   = 8'($urandom);
      density = $urandom_range(30, 100);
      for (int c = 0; c < 300 && !exp_valid; c++)
        step(1'($urandom_range(0, 99) < density), 1'($urandom_range(0, 99) == 0));
      check_eq("rand_valid", config_valid, 1'b1);
      check_eq("rand_cfg", config_out, frame);
    end

    // Full-size frame with don't-care (X) fields.
    for (int i = 0; i < NB; i++) begin
      big_care[i]  = ($urandom_range(0, 7) != 0);
      big_frame[i] = big_care[i] ? 1'($urandom) : 1'b0;
    end
    big_idx    = 0;
    big_enable = 1'b1;
    for (int e = 0; e < NB + 5; e++) begin
      @(posedge clock);
      #1;
      big_done = (big_idx == NB);
      if (big_idx < NB) begin
        big_bitstream = big_care[NB-1-big_idx] ? big_frame[NB-1-big_idx] : 1'bx;
        big_idx++;
      end else begin
        big_bitstream = 1'bx;
      end
    end
    check_eq("big_cfg_masked", big_config_out & big_care, big_frame);
    check_eq("big_bit_count", big_bit_count, 32'd465);
    check_eq("big_valid", big_config_valid, 1'b1);
    check_eq("big_error", big_error, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
